// File: rtl/reg_file_pkg.sv
// Shared register-file constants, types and the one-hot address decoder
// used by the write queue for both the storage select and the pending mask.
package reg_file_pkg;

  localparam int WORD_LENGTH = 32;
  localparam int ADDR_WIDTH  = 5;
  localparam int NUM_REGS    = 2 ** ADDR_WIDTH;

  typedef logic [ADDR_WIDTH-1:0]  reg_addr_t;
  typedef logic [WORD_LENGTH-1:0] word_t;
  typedef logic [NUM_REGS-1:0]    reg_mask_t;

  typedef struct packed {
    reg_addr_t addr;
    word_t     data;
  } wq_entry_t;

  function automatic reg_mask_t onehot_decode(input reg_addr_t addr);
    reg_mask_t mask;
    mask       = '0;
    mask[addr] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/reg_write_queue_if.sv
// Valid/ready write-request channel into the register write queue.
interface reg_write_queue_if;
  import reg_file_pkg::*;

  logic      wr_valid_i;
  logic      wr_ready_o;
  reg_addr_t wr_addr_i;
  word_t     wr_data_i;

  modport master (
    output wr_valid_i,
    output wr_addr_i,
    output wr_data_i,
    input  wr_ready_o
  );

  modport slave (
    input  wr_valid_i,
    input  wr_addr_i,
    input  wr_data_i,
    output wr_ready_o
  );

endinterface

// File: rtl/wq_fifo.sv
// Synchronous DEPTH-entry FIFO of register write requests; exposes every
// slot's address and occupancy so the top level can build the pending mask.
module wq_fifo
  import reg_file_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push_i,
  input  wq_entry_t              push_entry_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  output wq_entry_t              head_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic                   entry_valid_o [DEPTH],
  output reg_addr_t              entry_addr_o  [DEPTH]
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  wq_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push_i) tail_d = tail_q + 1'b1;
      if (pop_i)  head_d = head_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[tail_q] <= push_entry_i;
  end

  assign head_o  = mem_q[head_q];
  assign count_o = count_q;
  assign full_o  = (count_q == FULL_COUNT);
  assign empty_o = (count_q == '0);

  // A slot is live when its distance from the head is below the count.
  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    logic [PTR_W-1:0] offset;
    assign offset           = PTR_W'(i) - head_q;
    assign entry_valid_o[i] = ({1'b0, offset} < count_q);
    assign entry_addr_o[i]  = mem_q[i].addr;
  end

endmodule

// File: rtl/reg_write_queue.sv
// Register-file write queue and port driver: buffers write requests, drains
// one per cycle as a registered strobe/one-hot select/data, and flags pending writes.
module reg_write_queue
  import reg_file_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  reg_write_queue_if.slave       wr_if,
  input  logic                   stall_i,
  input  logic                   flush_i,
  output logic                   Reg_Write_o,
  output reg_mask_t              CP_o,
  output word_t                  data_o,
  output reg_mask_t              pending_o,
  output logic [$clog2(DEPTH):0] count_o
);

  wq_entry_t pushEntry;
  wq_entry_t headEntry;
  logic      fifoFull;
  logic      fifoEmpty;
  logic      doPush;
  logic      doPop;
  logic      entryValid [DEPTH];
  reg_addr_t entryAddr  [DEPTH];

  logic      regWrite_q, regWrite_d;
  reg_mask_t cp_q, cp_d;
  word_t     data_q, data_d;

  // Ready depends only on the registered count, so a pop never frees a slot early.
  assign wr_if.wr_ready_o = !fifoFull;
  assign doPush           = wr_if.wr_valid_i && !fifoFull && !flush_i;
  assign doPop            = !fifoEmpty && !stall_i && !flush_i;
  assign pushEntry        = '{addr: wr_if.wr_addr_i, data: wr_if.wr_data_i};

  wq_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk           (clk),
    .reset         (reset),
    .push_i        (doPush),
    .push_entry_i  (pushEntry),
    .pop_i         (doPop),
    .flush_i       (flush_i),
    .head_o        (headEntry),
    .count_o       (count_o),
    .full_o        (fifoFull),
    .empty_o       (fifoEmpty),
    .entry_valid_o (entryValid),
    .entry_addr_o  (entryAddr)
  );

  // Data word holds when nothing drains; strobe and select drop to zero.
  always_comb begin
    regWrite_d = doPop;
    cp_d       = doPop ? onehot_decode(headEntry.addr) : '0;
    data_d     = doPop ? headEntry.data : data_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      regWrite_q <= 1'b0;
      cp_q       <= '0;
      data_q     <= '0;
    end else begin
      regWrite_q <= regWrite_d;
      cp_q       <= cp_d;
      data_q     <= data_d;
    end
  end

  assign Reg_Write_o = regWrite_q;
  assign CP_o        = cp_q;
  assign data_o      = data_q;

  // A register stays pending until the strobe targeting it has been captured.
  always_comb begin
    pending_o = regWrite_q ? cp_q : '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entryValid[i]) pending_o = pending_o | onehot_decode(entryAddr[i]);
    end
  end

endmodule

// File: tb/tb_reg_write_queue.sv
// Directed, table-driven bench for reg_write_queue plus a hand-written
// sustained-throughput sequence.
module tb_reg_write_queue;

  typedef struct {
    logic        rstN;
    logic        valid;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        stall;
    logic        flush;
    logic        expReady;
    logic [2:0]  expCount;
    logic        expRw;
    logic [31:0] expCp;
    logic [31:0] expData;
    logic [31:0] expPend;
  } vec_t;

  logic        clk;
  logic        reset;
  logic        stall_i;
  logic        flush_i;
  logic        Reg_Write_o;
  logic [31:0] CP_o;
  logic [31:0] data_o;
  logic [31:0] pending_o;
  logic [2:0]  count_o;

  int errors;
  int checks;
  vec_t vecs[$];

  reg_write_queue_if wif ();

  reg_write_queue #(
    .DEPTH (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .wr_if       (wif),
    .stall_i     (stall_i),
    .flush_i     (flush_i),
    .Reg_Write_o (Reg_Write_o),
    .CP_o        (CP_o),
    .data_o      (data_o),
    .pending_o   (pending_o),
    .count_o     (count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mkVec(input logic r, input logic v, input logic [4:0] a,
                                 input logic [31:0] d, input logic s, input logic f,
                                 input logic er, input logic [2:0] ec, input logic erw,
                                 input logic [31:0] ecp, input logic [31:0] ed,
                                 input logic [31:0] ep);
    vec_t x;
    x.rstN = r; x.valid = v; x.addr = a; x.data = d; x.stall = s; x.flush = f;
    x.expReady = er; x.expCount = ec; x.expRw = erw;
    x.expCp = ecp; x.expData = ed; x.expPend = ep;
    return x;
  endfunction

  task automatic checkOutput(input string what, input int idx,
                             input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL step%0d %s: got 0x%0h expected 0x%0h", idx, what, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic v, input logic [4:0] a,
                               input logic [31:0] d, input logic s, input logic f);
    @(negedge clk);
    reset          = r;
    wif.wr_valid_i = v;
    wif.wr_addr_i  = a;
    wif.wr_data_i  = d;
    stall_i        = s;
    flush_i        = f;
    @(posedge clk);
    #1;
  endtask

  initial begin
    errors         = 0;
    checks         = 0;
    reset          = 1'b0;
    stall_i        = 1'b0;
    flush_i        = 1'b0;
    wif.wr_valid_i = 1'b0;
    wif.wr_addr_i  = '0;
    wif.wr_data_i  = '0;

    // rst valid addr data stall flush | ready count rw cp data pending
    vecs.push_back(mkVec(0,0, 0,32'h0,       0,0, 1,0,0,32'h0,  32'h0,       32'h0));
    vecs.push_back(mkVec(1,1, 5,32'hDEADBEEF,0,0, 1,1,0,32'h0,  32'h0,       32'h20));
    vecs.push_back(mkVec(1,0, 0,32'h0,       0,0, 1,0,1,32'h20, 32'hDEADBEEF,32'h20));
    vecs.push_back(mkVec(1,0, 0,32'h0,       0,0, 1,0,0,32'h0,  32'hDEADBEEF,32'h0));
    vecs.push_back(mkVec(1,1, 1,32'h101,     1,0, 1,1,0,32'h0,  32'hDEADBEEF,32'h2));
    vecs.push_back(mkVec(1,1, 2,32'h102,     1,0, 1,2,0,32'h0,  32'hDEADBEEF,32'h6));
    vecs.push_back(mkVec(1,1, 3,32'h103,     1,0, 1,3,0,32'h0,  32'hDEADBEEF,32'hE));
    vecs.push_back(mkVec(1,1, 4,32'h104,     1,0, 0,4,0,32'h0,  32'hDEADBEEF,32'h1E));
    vecs.push_back(mkVec(1,1, 5,32'h105,     1,0, 0,4,0,32'h0,  32'hDEADBEEF,32'h1E));
    vecs.push_back(mkVec(1,1, 5,32'h105,     0,0, 1,3,1,32'h2,  32'h101,     32'h1E));
    vecs.push_back(mkVec(1,1, 5,32'h105,     0,0, 1,3,1,32'h4,  32'h102,     32'h3C));
    vecs.push_back(mkVec(1,0, 0,32'h0,       0,0, 1,2,1,32'h8,  32'h103,     32'h38));
    vecs.push_back(mkVec(1,0, 0,32'h0,       0,0, 1,1,1,32'h10, 32'h104,     32'h30));
    vecs.push_back(mkVec(1,0, 0,32'h0,       0,0, 1,0,1,32'h20, 32'h105,     32'h20));
    vecs.push_back(mkVec(1,0, 0,32'h0,       0,0, 1,0,0,32'h0,  32'h105,     32'h0));
    vecs.push_back(mkVec(1,1,10,32'hA,       1,0, 1,1,0,32'h0,  32'h105,     32'h400));
    vecs.push_back(mkVec(1,1,11,32'hB,       1,0, 1,2,0,32'h0,  32'h105,     32'hC00));
    vecs.push_back(mkVec(1,1,12,32'hC,       1,0, 1,3,0,32'h0,  32'h105,     32'h1C00));
    vecs.push_back(mkVec(1,1,13,32'hD,       0,1, 1,0,0,32'h0,  32'h105,     32'h0));
    vecs.push_back(mkVec(1,0, 0,32'h0,       0,0, 1,0,0,32'h0,  32'h105,     32'h0));
    vecs.push_back(mkVec(1,0, 0,32'h0,       0,0, 1,0,0,32'h0,  32'h105,     32'h0));
    vecs.push_back(mkVec(1,1, 7,32'h71,      0,0, 1,1,0,32'h0,  32'h105,     32'h80));
    vecs.push_back(mkVec(1,1, 7,32'h72,      0,0, 1,1,1,32'h80, 32'h71,      32'h80));
    vecs.push_back(mkVec(1,0, 0,32'h0,       0,0, 1,0,1,32'h80, 32'h72,      32'h80));
    vecs.push_back(mkVec(1,0, 0,32'h0,       0,0, 1,0,0,32'h0,  32'h72,      32'h0));
    vecs.push_back(mkVec(1,1, 3,32'h33,      1,0, 1,1,0,32'h0,  32'h72,      32'h8));
    vecs.push_back(mkVec(1,1, 4,32'h44,      1,0, 1,2,0,32'h0,  32'h72,      32'h18));
    vecs.push_back(mkVec(1,1, 6,32'h66,      0,0, 1,2,1,32'h8,  32'h33,      32'h58));
    vecs.push_back(mkVec(0,1, 9,32'h99,      0,0, 1,0,0,32'h0,  32'h0,       32'h0));
    vecs.push_back(mkVec(1,1, 0,32'h1234,    0,0, 1,1,0,32'h0,  32'h0,       32'h1));
    vecs.push_back(mkVec(1,0, 0,32'h0,       0,0, 1,0,1,32'h1,  32'h1234,    32'h1));
    vecs.push_back(mkVec(1,0, 0,32'h0,       0,0, 1,0,0,32'h0,  32'h1234,    32'h0));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rstN, vecs[i].valid, vecs[i].addr, vecs[i].data,
                    vecs[i].stall, vecs[i].flush);
      checkOutput("wr_ready", i, {31'b0, wif.wr_ready_o}, {31'b0, vecs[i].expReady});
      checkOutput("count",    i, {29'b0, count_o},        {29'b0, vecs[i].expCount});
      checkOutput("Reg_Write",i, {31'b0, Reg_Write_o},    {31'b0, vecs[i].expRw});
      checkOutput("CP",       i, CP_o,                    vecs[i].expCp);
      checkOutput("data",     i, data_o,                  vecs[i].expData);
      checkOutput("pending",  i, pending_o,               vecs[i].expPend);
    end

    // Continuous push with no stall must strobe once per cycle.
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b1, 1'b1, 5'(16 + k), 32'hC0 + 32'(k), 1'b0, 1'b0);
      checkOutput("tput_count", 100 + k, {29'b0, count_o}, 32'd1);
      if (k > 0) begin
        checkOutput("tput_rw",   100 + k, {31'b0, Reg_Write_o}, 32'd1);
        checkOutput("tput_cp",   100 + k, CP_o, 32'd1 << (15 + k));
        checkOutput("tput_data", 100 + k, data_o, 32'hC0 + 32'(k - 1));
      end
    end
    applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    checkOutput("tput_count", 108, {29'b0, count_o}, 32'd0);
    checkOutput("tput_rw",    108, {31'b0, Reg_Write_o}, 32'd1);
    checkOutput("tput_cp",    108, CP_o, 32'h0080_0000);
    checkOutput("tput_data",  108, data_o, 32'hC7);
    applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    checkOutput("tput_rw",    109, {31'b0, Reg_Write_o}, 32'd0);
    checkOutput("tput_pend",  109, pending_o, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_write_queue.md
# reg_write_queue

Write-request queue and port driver directly upstream of the 32-entry register-file storage array. Accepts register write requests over a valid/ready handshake and buffers up to DEPTH of them. Drains one request per cycle as a one-hot register select, a write strobe and a data word, which the storage array ANDs per register and captures. Publishes a pending-write mask so hazard logic can stall reads of registers whose writes have not yet landed.

## Interface
- WORD_LENGTH, 32, data width of every register.
- ADDR_WIDTH, 5, register address width; NUM_REGS = 2**ADDR_WIDTH = 32.
- DEPTH, 4, queue entries; power of two, at least 2.

Clock and reset (already decided): one clock `clk`; reset port `reset` is synchronous and active-low.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous active-low reset.
- wr_valid_i  in  1  write request present.
- wr_ready_o  out  1  queue can accept; equals (count_o != DEPTH).
- wr_addr_i  in  ADDR_WIDTH  destination register.
- wr_data_i  in  WORD_LENGTH  write data.
- stall_i  in  1  hold drain; no pop while high.
- flush_i  in  1  discard all queued and in-flight writes.
- Reg_Write_o  out  1  write strobe to storage, registered.
- CP_o  out  NUM_REGS  one-hot register select, registered; all-zero when Reg_Write_o = 0.
- data_o  out  WORD_LENGTH  write data to storage, registered.
- pending_o  out  NUM_REGS  bit i = 1 while any queued entry or the output register targets register i.
- count_o  out  clog2(DEPTH)+1  occupied entries.

## Operation
- Push: at a rising edge with reset = 1, wr_valid_i = 1, wr_ready_o = 1 and flush_i = 0, store {wr_addr_i, wr_data_i} at the tail.
- Pop: at an edge with the queue non-empty, stall_i = 0 and flush_i = 0, remove the head and load the output register with Reg_Write_o = 1, CP_o = 1 << head_addr and data_o = head_data.
- No pop at an edge: Reg_Write_o = 0 and CP_o = 0. data_o holds its last value.
- Push and pop at the same edge are both legal. count_o is unchanged.
- Full: wr_ready_o = 0, even if a pop happens at the same edge. There is no same-cycle slot reuse.
- Empty plus push: there is no bypass. The entry is visible at the head next cycle.
- Flush: at the edge, count_o becomes 0, pointers reset, Reg_Write_o becomes 0 and CP_o becomes 0. Flush dominates push and pop; the request presented at that edge is dropped.
- Stall: holds the queue and sets Reg_Write_o to 0 next cycle. Pushes continue while not full.
- pending_o is combinational from registered state: OR of the decoded addresses of valid entries, OR CP_o when Reg_Write_o = 1.
- Register address 0 is treated like any other register.
- Reset (reset = 0 at an edge) clears everything: count_o = 0, Reg_Write_o = 0, CP_o = 0, data_o = 0, pending_o = 0. wr_ready_o = 1 after the first reset edge.
- Reset mid-operation discards queued entries. No partial write is issued.

## Timing
- Push accepted at edge N into an empty, unstalled queue:
  - Reg_Write_o, CP_o and data_o are valid after edge N+1.
  - The storage captures at edge N+2.
  - Pipeline latency is 2 edges.
- Throughput: one write per cycle sustained with continuous push and no stall.
- pending_o bit rises after the push edge. It falls after the edge at which the storage captures: the first edge where Reg_Write_o was 1 and no other entry targets that register.
- count_o and wr_ready_o update only at edges. There are no combinational paths from wr_valid_i.

## Structure
- Shared package `reg_file_pkg` holds:
  - constants WORD_LENGTH, ADDR_WIDTH and NUM_REGS;
  - a `reg_addr_t` typedef;
  - a function `onehot_decode(addr)` returning the NUM_REGS one-hot vector, used for both CP_o and pending_o.
- Sub-module `wq_fifo` is a synchronous DEPTH-entry FIFO:
  - contents: storage, head/tail pointers and count;
  - exposes: head entry, per-entry valid and address for the pending mask, and flush.
- The top level holds the output register and the pending-mask logic.

## Test plan
- Reset, then push addr 5 with data 0xDEADBEEF → Reg_Write_o = 1, CP_o = 0x00000020 and data_o = 0xDEADBEEF two edges after the push; pending_o[5] = 1 during those cycles.
- Push 5 back-to-back requests (addrs 1–5) with stall_i = 1 → count_o = 4, wr_ready_o = 0 and the 5th request is not accepted. Release stall → strobes for 1, 2, 3, 4 on consecutive cycles. The 5th is accepted after the first pop edge.
- Full queue, push and pop at the same edge → the push is refused (wr_ready_o = 0) and count_o goes 4 → 3.
- Queue holding 3 entries, assert flush_i together with a valid push → next cycle count_o = 0, Reg_Write_o = 0, pending_o = 0 and no strobe is ever issued for the dropped entries.
- Two queued writes to addr 7 → pending_o[7] stays 1 until after the second strobe's capture edge.
- Drive reset = 0 for one edge while entries are queued and a strobe is in flight → all outputs 0 and wr_ready_o = 1 afterwards. Then push addr 0 → CP_o = 0x00000001.
